apb_slave: RTL

APB_SLAVE -- requirements
Module: apb_slave

---
 rtl/apb_slave.sv | 110 +++++++++++
 1 files changed

// File: rtl/apb_slave.sv
// apb_slave: APB register-file slave with programmable wait states and byte strobes
module apb_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_SIZE   = 4,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic                  enable,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_SIZE-1:0]  strobe,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  slverr
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic [3:0] cnt, cnt_next;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic lat_write;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [STRB_SIZE-1:0] lat_strb;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic setup;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic cur_write, cur_oor, lat_oor;
  assign setup     = state == IDLE && sel && !enable;
  // With zero wait states RESP is entered straight from the setup cycle, before the latch holds the request
  assign cur_addr  = setup ? addr : lat_addr;
  assign cur_write = setup ? write : lat_write;
  assign cur_oor   = |(cur_addr >> AW);
  assign lat_oor   = |(lat_addr >> AW);
  // Next-state and wait counter
  always_comb begin
    next = state;
    cnt_next = cnt;
    case (state)
      IDLE: if (setup) begin
        next = WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt_next = 4'(WAIT_CYCLES);
      end
      WAIT: if (!sel) begin
        next = IDLE;
        cnt_next = '0;
      end else if (enable) begin
        next = cnt == 4'd1 ? RESP : WAIT;
        cnt_next = cnt - 4'd1;
      end
      RESP: begin
        next = IDLE;
        cnt_next = '0;
      end
      default: begin
        next = IDLE;
        cnt_next = '0;
      end
    endcase
  end
  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= cnt_next;
    end
  end
  // Capture the request during the setup cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_strb <= '0;
    end else if (setup) begin
      lat_addr <= addr;
      lat_write <= write;
      lat_wdata <= wdata;
      lat_strb <= strobe;
    end
  end
  // Registered response, only non-zero for the single RESP cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
      slverr <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= next == RESP;
      slverr <= next == RESP && cur_oor;
      rdata <= next == RESP && !cur_write && !cur_oor ? mem[cur_addr[AW-1:0]] : '0;
    end
  end
  // Byte-masked write committed on the edge that ends RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (state == RESP && lat_write && !lat_oor) begin
      for (int i = 0; i < STRB_SIZE; i++)
        if (lat_strb[i]) mem[lat_addr[AW-1:0]][8*i +: 8] <= lat_wdata[8*i +: 8];
    end
  end
endmodule
